keypad_matrix_scan: RTL and testbench

Matrix keypad scanner, the input-side counterpart of the multiplexed 7-segment digit drivers. It walks an active-low strobe across the keypad rows, one row at a time, and samples the active-low column lines. It debounces whole scan frames and emits a one-cycle key event with a row-major key code. It sits beside the display drivers in top, with keypad pins routed to IO. Its key_code/key_valid outputs feed the display or memory-address logic.

---
 rtl/keypad_matrix_scan.sv | 163 ++++++++++++++++
 tb/tb_keypad_matrix_scan.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_matrix_scan.sv
// rtl/keypad_matrix_scan.sv - row-strobed matrix keypad scanner with frame debounce
module keypad_matrix_scan #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 100000,
  parameter int DEBOUNCE = 4,
  localparam int KW      = $clog2(ROWS * COLS)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [ROWS-1:0] rows_n,
  input  logic [COLS-1:0] cols_n,
  output logic            key_valid,
  output logic [KW-1:0]   key_code,
  output logic            key_down
);

  localparam int KEYS = ROWS * COLS;
  localparam int DW   = $clog2(SCAN_DIV);
  localparam int RW   = $clog2(ROWS);
  localparam int SW   = $clog2(DEBOUNCE + 1);

  typedef enum logic {
    IDLE,
    PRESSED
  } state_t;

  logic [COLS-1:0] cols_meta;
  logic [COLS-1:0] cols_sync;
  logic [DW-1:0]   div;
  logic [RW-1:0]   row;
  logic [RW-1:0]   row_next;
  logic [ROWS-1:0] rows_n_next;
  logic [KEYS-1:0] frame;
  logic [KEYS-1:0] full_frame;
  logic [KEYS-1:0] prev_frame;
  logic [KEYS-1:0] debounced;
  logic [KEYS-1:0] dbn_next;
  logic [SW-1:0]   stable;
  logic            tc;
  logic            frame_done;
  logic            frame_same;
  logic            dbn_upd;
  logic [KW-1:0]   lowest;
  state_t          state;
  state_t          state_next;
  logic            valid_next;
  logic [KW-1:0]   code_next;
  logic            down_next;

  // Two-flop synchroniser for the asynchronous column lines (idle = pulled up)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cols_meta <= '1;
      cols_sync <= '1;
    end else begin
      cols_meta <= cols_n;
      cols_sync <= cols_meta;
    end
  end

  // Scan timing, frame assembly (current row spliced in live) and next strobe pattern
  always_comb begin
    tc         = (div == DW'(SCAN_DIV - 1));
    frame_done = tc && (row == RW'(ROWS - 1));
    row_next   = (row == RW'(ROWS - 1)) ? '0 : row + RW'(1);
    full_frame = frame;
    for (int i = 0; i < ROWS; i++) begin
      if (row == RW'(i)) full_frame[i*COLS +: COLS] = ~cols_sync;
      rows_n_next[i] = (row_next != RW'(i));
    end
    frame_same = (full_frame == prev_frame);
    dbn_upd    = frame_done && frame_same && (stable == SW'(DEBOUNCE - 1));
    dbn_next   = dbn_upd ? full_frame : debounced;
  end

  // Row divider, row index, strobe outputs and per-row column capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div    <= '0;
      row    <= '0;
      rows_n <= {{(ROWS-1){1'b1}}, 1'b0};
      frame  <= '0;
    end else if (tc) begin
      div    <= '0;
      row    <= row_next;
      rows_n <= rows_n_next;
      frame  <= full_frame;
    end else begin
      div <= div + DW'(1);
    end
  end

  // Frame-level debounce: count consecutive identical frames, commit on reaching DEBOUNCE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_frame <= '0;
      stable     <= '0;
      debounced  <= '0;
    end else begin
      if (frame_done) begin
        if (frame_same) begin
          if (stable != SW'(DEBOUNCE)) stable <= stable + SW'(1);
        end else begin
          stable     <= '0;
          prev_frame <= full_frame;
        end
      end
      debounced <= dbn_next;
    end
  end

  // Lowest pressed key index wins when several keys are closed
  always_comb begin
    lowest = '0;
    for (int i = KEYS - 1; i >= 0; i--) begin
      if (dbn_next[i]) lowest = KW'(i);
    end
  end

  // Press/release state machine; acts only on a debounce commit, locks out rollover
  always_comb begin
    state_next = state;
    valid_next = 1'b0;
    code_next  = key_code;
    down_next  = key_down;
    if (dbn_upd) begin
      case (state)
        IDLE: begin
          if (dbn_next != '0) begin
            valid_next = 1'b1;
            code_next  = lowest;
            down_next  = 1'b1;
            state_next = PRESSED;
          end
        end
        PRESSED: begin
          if (dbn_next == '0) begin
            down_next  = 1'b0;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_down  <= 1'b0;
    end else begin
      state     <= state_next;
      key_valid <= valid_next;
      key_code  <= code_next;
      key_down  <= down_next;
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// tb/tb_keypad_matrix_scan.sv - scoreboard bench for keypad_matrix_scan
module tb_keypad_matrix_scan;

  logic        clk;
  logic        rst_n;
  logic [3:0]  rows_n;
  logic [3:0]  cols_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_down;
  logic [15:0] keys;

  int compared;
  int mismatched;
  int exp_q[$];

  keypad_matrix_scan #(
    .ROWS(4), .COLS(4), .SCAN_DIV(8), .DEBOUNCE(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rows_n(rows_n), .cols_n(cols_n),
    .key_valid(key_valid), .key_code(key_code), .key_down(key_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: a closed key shorts its column to the strobed row
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      cols_n[c] = 1'b1;
      for (int r = 0; r < 4; r++) begin
        if (keys[r*4+c] && !rows_n[r]) cols_n[c] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every key_valid pulse must match the next expected code
  always @(negedge clk) begin
    int e;
    if (key_valid) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_pulse: got code %0d, expected no pulse", key_code);
      end else begin
        e = exp_q.pop_front();
        check("key_code", int'(key_code), e);
      end
    end
  end

  task automatic wait_pulse(input int max);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("pulse_latency_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_down(input string name, input logic val, input int max);
    int n;
    n = 0;
    while (key_down !== val && n < max) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(key_down), int'(val));
  endtask

  task automatic wait_rows(input logic [3:0] val);
    int n;
    n = 0;
    while (rows_n !== val && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("wait_rows", int'(rows_n), int'(val));
  endtask

  initial begin
    logic [3:0] prev;
    int since;
    int nchg;
    int bad_down;
    compared   = 0;
    mismatched = 0;
    keys       = '0;
    rst_n      = 1'b0;

    // 1: reset values and idle scan sequence
    repeat (3) @(negedge clk);
    check("reset_rows_n", int'(rows_n), 4'b1110);
    check("reset_key_valid", int'(key_valid), 0);
    check("reset_key_code", int'(key_code), 0);
    check("reset_key_down", int'(key_down), 0);
    rst_n = 1'b1;
    prev = rows_n;
    since = 0;
    nchg = 0;
    bad_down = 0;
    repeat (200) begin
      @(negedge clk);
      since++;
      if (rows_n !== prev) begin
        check("row_sequence", int'(rows_n), int'({prev[2:0], prev[3]}));
        if (nchg > 0) check("row_period", since, 8);
        nchg++;
        prev = rows_n;
        since = 0;
      end
      if (key_down) bad_down = 1;
    end
    check("idle_key_down", bad_down, 0);
    check("idle_key_code", int'(key_code), 0);
    check("idle_row_changes", int'(nchg >= 24), 1);

    // 2: clean press of r2,c1 (code 9)
    keys[9] = 1'b1;
    exp_q.push_back(9);
    wait_pulse(164);
    repeat (150) @(negedge clk);
    check("held_key_down", int'(key_down), 1);
    keys[9] = 1'b0;
    wait_down("release_key_down", 1'b0, 164);

    // 3: chatter on r1,c3 (code 7) aligned to the row1 slot start, then hold
    wait_rows(4'b1110);
    wait_rows(4'b1101);
    for (int i = 0; i < 12; i++) begin
      keys[7] = (i % 2 == 0);
      repeat (20) @(negedge clk);
    end
    check("chatter_key_down", int'(key_down), 0);
    keys[7] = 1'b1;
    exp_q.push_back(7);
    wait_pulse(164);
    keys[7] = 1'b0;
    wait_down("chatter_release", 1'b0, 164);

    // 4: two keys, lowest wins, rollover lockout
    keys[5]  = 1'b1;
    keys[14] = 1'b1;
    exp_q.push_back(5);
    wait_pulse(164);
    keys[5] = 1'b0;
    repeat (200) @(negedge clk);
    check("rollover_key_down", int'(key_down), 1);
    check("rollover_key_code", int'(key_code), 5);
    keys = '0;
    wait_down("rollover_release", 1'b0, 164);
    keys[14] = 1'b1;
    exp_q.push_back(14);
    wait_pulse(164);
    keys = '0;
    wait_down("code14_release", 1'b0, 164);

    // 5: asynchronous reset while code 0 is held
    keys[0] = 1'b1;
    exp_q.push_back(0);
    wait_pulse(164);
    check("pre_reset_key_down", int'(key_down), 1);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rows_n", int'(rows_n), 4'b1110);
    check("async_key_down", int'(key_down), 0);
    check("async_key_valid", int'(key_valid), 0);
    check("async_key_code", int'(key_code), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(0);
    wait_pulse(164);
    keys = '0;
    wait_down("post_reset_release", 1'b0, 164);

    // 6: sweep all keys
    for (int k = 0; k < 16; k++) begin
      keys = 16'(1) << k;
      exp_q.push_back(k);
      wait_pulse(164);
      keys = '0;
      wait_down("sweep_release", 1'b0, 164);
    end

    repeat (100) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
